ball_motion_ctrl: RTL

//  Owns the ball: holds it on the paddle while aiming, latches the 3-bit aim angle code
//  on launch, then steps the position once per frame tick with wall/paddle/brick

---
 rtl/brick_pkg.sv | 29 ++
 rtl/ball_step_unit.sv | 79 +++++++
 rtl/ball_motion_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/brick_pkg.sv
// Shared types for the ball/brick datapath: aim codes, ball FSM states and
// the aim-code to velocity decode.
package brick_pkg;

  typedef logic [2:0]        angle_t;
  typedef logic signed [2:0] vel_t;

  typedef enum logic [1:0] {HELD, MOVE, LOST} ball_state_t;

  typedef struct packed {
    vel_t dx;
    vel_t dy;
  } vec_t;

  // Codes 6 and 7 are unused by the aim selector and fold onto the default (+1,-1).
  function automatic vec_t angle_to_vec(input angle_t code);
    vec_t v;
    case (code)
      3'd0:    begin v.dx = -3'sd2; v.dy = -3'sd1; end
      3'd1:    begin v.dx = -3'sd1; v.dy = -3'sd1; end
      3'd2:    begin v.dx = -3'sd1; v.dy = -3'sd2; end
      3'd3:    begin v.dx =  3'sd1; v.dy = -3'sd2; end
      3'd5:    begin v.dx =  3'sd2; v.dy = -3'sd1; end
      default: begin v.dx =  3'sd1; v.dy = -3'sd1; end
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ball_step_unit.sv
// Combinational single-tick motion step: brick, floor, wall and paddle
// reflection in priority order, computed in 10-bit signed space.
module ball_step_unit
  import brick_pkg::*;
#(
  parameter int X_MAX    = 255,
  parameter int Y_MAX    = 255,
  parameter int PADDLE_Y = 240,
  parameter int PADDLE_W = 32
) (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  vel_t       dx,
  input  vel_t       dy,
  input  logic [7:0] paddle_x,
  input  logic       brick_hit,
  input  logic       hit_vert,
  output logic [7:0] next_x,
  output logic [7:0] next_y,
  output vel_t       next_dx,
  output vel_t       next_dy,
  output logic       lost
);

  localparam logic signed [9:0] XMAX10 = 10'(X_MAX);
  localparam logic signed [9:0] YMAX10 = 10'(Y_MAX);
  localparam logic signed [9:0] REST10 = 10'(PADDLE_Y - 1);

  logic signed [9:0] nx, ny;
  logic        [9:0] pad_right;
  logic              wall_lo_x, wall_hi_x, wall_y, on_paddle;

  assign nx        = $signed({2'b00, x}) + 10'(dx);
  assign ny        = $signed({2'b00, y}) + 10'(dy);
  assign pad_right = {2'b00, paddle_x} + 10'(PADDLE_W - 1);
  assign wall_lo_x = nx < 10'sd0;
  assign wall_hi_x = nx > XMAX10;
  assign wall_y    = ny < 10'sd0;
  assign on_paddle = (dy > 3'sd0) && (ny >= REST10) &&
                     ({2'b00, x} >= {2'b00, paddle_x}) && ({2'b00, x} <= pad_right);

  // NOTE: every output gets a default first so no path through the priority chain infers a latch.
  always_comb begin
    next_x  = x;
    next_y  = y;
    next_dx = dx;
    next_dy = dy;
    lost    = 1'b0;
    if (brick_hit) begin
      if (hit_vert) next_dx = -dx;
      else          next_dy = -dy;
    end else if (ny > YMAX10) begin
      lost = 1'b1;
    end else if (wall_lo_x || wall_hi_x || wall_y) begin
      // Each axis clamps independently, so a corner flips both components.
      next_x = nx[7:0];
      next_y = ny[7:0];
      if (wall_lo_x) begin
        next_x  = 8'd0;
        next_dx = -dx;
      end else if (wall_hi_x) begin
        next_x  = XMAX10[7:0];
        next_dx = -dx;
      end
      if (wall_y) begin
        next_y  = 8'd0;
        next_dy = -dy;
      end
    end else if (on_paddle) begin
      next_x  = nx[7:0];
      next_y  = REST10[7:0];
      next_dy = -dy;
    end else begin
      next_x = nx[7:0];
      next_y = ny[7:0];
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball owner: tracks the paddle while held, launches on the aim code and
// steps the ball once per frame tick until it drops out of the bottom.
module ball_motion_ctrl
  import brick_pkg::*;
#(
  parameter int X_MAX    = 255,
  parameter int Y_MAX    = 255,
  parameter int PADDLE_Y = 240,
  parameter int PADDLE_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       launch,
  input  angle_t     angle_in,
  input  logic [7:0] paddle_x,
  input  logic       brick_hit,
  input  logic       hit_vert,
  output logic [7:0] ball_x,
  output logic [7:0] ball_y,
  output logic       moving,
  output logic       ball_lost
);

  localparam logic [7:0] REST_Y = 8'(PADDLE_Y - 1);

  ball_state_t state, next_state;
  vel_t        dx, dy;
  vec_t        launch_vec;
  logic [8:0]  track_sum;
  logic [7:0]  track_x;
  logic [7:0]  step_x, step_y;
  vel_t        step_dx, step_dy;
  logic        step_lost;
  logic        moving_d, lost_d;

  assign launch_vec = angle_to_vec(angle_in);
  assign track_sum  = {1'b0, paddle_x} + 9'(PADDLE_W / 2);
  assign track_x    = (track_sum > 9'(X_MAX)) ? 8'(X_MAX) : track_sum[7:0];

  ball_step_unit #(
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .PADDLE_Y(PADDLE_Y), .PADDLE_W(PADDLE_W)
  ) u_step (
    .x(ball_x), .y(ball_y), .dx(dx), .dy(dy),
    .paddle_x(paddle_x), .brick_hit(brick_hit), .hit_vert(hit_vert),
    .next_x(step_x), .next_y(step_y), .next_dx(step_dx), .next_dy(step_dy),
    .lost(step_lost)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= HELD;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      HELD:    if (launch) next_state = MOVE;
      MOVE:    if (tick && step_lost) next_state = LOST;
      LOST:    next_state = HELD;
      default: next_state = HELD;
    endcase
  end

  // NOTE: flags are decoded from next_state and registered, so they line up with state without a comb path.
  always_comb begin
    moving_d = (next_state == MOVE);
    lost_d   = (next_state == LOST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      moving    <= 1'b0;
      ball_lost <= 1'b0;
    end else begin
      moving    <= moving_d;
      ball_lost <= lost_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ball_x <= 8'd128;
      ball_y <= REST_Y;
      dx     <= 3'sd1;
      dy     <= -3'sd1;
    end else begin
      case (state)
        HELD: begin
          ball_x <= track_x;
          ball_y <= REST_Y;
          if (launch) begin
            dx <= launch_vec.dx;
            dy <= launch_vec.dy;
          end
        end
        MOVE: if (tick) begin
          ball_x <= step_x;
          ball_y <= step_y;
          dx     <= step_dx;
          dy     <= step_dy;
        end
        default: ;
      endcase
    end
  end

endmodule
